// File: rtl/pins_event_monitor.sv
// pins_event_monitor: synchronises and deglitches pin levels, then queues each accepted
// level change as a timestamped edge event behind a valid/ready port.

// Per-pin front end: 2-flop synchroniser, glitch filter and a one-entry edge holding slot.
module pins_event_lane #(
    parameter int   FilterCycles = 4,
    parameter int   TsWidth      = 16,
    parameter logic ResetVal     = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pin_i,
    input  logic               en_i,
    input  logic               filter_en_i,
    input  logic               clear_i,
    input  logic               take_i,
    input  logic [TsWidth-1:0] ts_i,
    output logic               stable_o,
    output logic               pending_o,
    output logic               rise_o,
    output logic [TsWidth-1:0] ts_o,
    output logic               drop_o
);
    localparam int              CntW   = $clog2(FilterCycles) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

    logic            sync1, sync2;
    logic [CntW-1:0] cnt;
    logic            known, differ, upd, capture;

    // X/Z on the raw pin must never reach the filter, so such samples are ignored.
    assign known   = (pin_i === 1'b0) || (pin_i === 1'b1);
    assign differ  = sync2 != stable_o;
    assign upd     = differ && (!filter_en_i || cnt == CntMax);
    assign capture = en_i && upd;
    // A new edge while the slot is still occupied is lost.
    assign drop_o  = capture && pending_o;

    // Two-stage synchroniser; stage 1 holds its value on an unknown input sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= ResetVal;
            sync2 <= ResetVal;
        end else begin
            if (known) sync1 <= pin_i;
            sync2 <= sync1;
        end
    end

    // Glitch filter: accept a new level after FilterCycles consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_o <= ResetVal;
            cnt      <= '0;
        end else begin
            if (upd) stable_o <= sync2;
            if (!filter_en_i || !differ || upd) cnt <= '0;
            else                                cnt <= cnt + CntW'(1);
        end
    end

    // Edge holding slot: stores direction and timestamp until the arbiter takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_o <= 1'b0;
            rise_o    <= 1'b0;
            ts_o      <= '0;
        end else if (clear_i) begin
            pending_o <= 1'b0;
        end else if (capture && !pending_o) begin
            pending_o <= 1'b1;
            rise_o    <= sync2;
            ts_o      <= ts_i;
        end else if (take_i) begin
            pending_o <= 1'b0;
        end
    end
endmodule

// Top: per-pin lanes, lowest-index-first arbiter, event FIFO, timestamp and overflow flag.
module pins_event_monitor #(
    parameter int               Width        = 1,
    parameter int               FilterCycles = 4,
    parameter int               FifoDepth    = 8,
    parameter int               TsWidth      = 16,
    parameter logic [Width-1:0] ResetVal     = '0,
    localparam int              IdxW         = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [Width-1:0]             pins_i,
    input  logic                         en_i,
    input  logic                         filter_en_i,
    input  logic                         clear_i,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic [IdxW-1:0]              evt_pin_o,
    output logic                         evt_rise_o,
    output logic [TsWidth-1:0]           evt_ts_o,
    output logic [Width-1:0]             stable_o,
    output logic [$clog2(FifoDepth):0]   depth_o,
    output logic                         overflow_o
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int DepW = PtrW + 1;

    typedef struct packed {
        logic [IdxW-1:0]    pin;
        logic               rise;
        logic [TsWidth-1:0] ts;
    } evt_t;

    logic [TsWidth-1:0]            ts_cnt;
    logic [Width-1:0]              pending, rise, take, drop;
    logic [Width-1:0][TsWidth-1:0] lane_ts;
    evt_t [FifoDepth-1:0]          mem;
    evt_t                          ent, head;
    logic [PtrW-1:0]               wr_ptr, rd_ptr;
    logic [DepW-1:0]               count;
    logic [IdxW-1:0]               sel;
    logic                          any, push, pop, full;

    for (genvar g = 0; g < Width; g++) begin : g_lane
        pins_event_lane #(
            .FilterCycles (FilterCycles),
            .TsWidth      (TsWidth),
            .ResetVal     (ResetVal[g])
        ) u_lane (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .pin_i        (pins_i[g]),
            .en_i         (en_i),
            .filter_en_i  (filter_en_i),
            .clear_i      (clear_i),
            .take_i       (take[g]),
            .ts_i         (ts_cnt),
            .stable_o     (stable_o[g]),
            .pending_o    (pending[g]),
            .rise_o       (rise[g]),
            .ts_o         (lane_ts[g]),
            .drop_o       (drop[g])
        );
    end

    // Priority select of the lowest-index pending pin and its event payload.
    always_comb begin
        any = 1'b0;
        sel = '0;
        ent = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any      = 1'b1;
                sel      = IdxW'(i);
                ent.pin  = IdxW'(i);
                ent.rise = rise[i];
                ent.ts   = lane_ts[i];
            end
        end
    end

    assign full = count == DepW'(FifoDepth);
    assign pop  = evt_valid_o && evt_ready_i;
    // A same-cycle pop frees the slot the push needs; clear overrides any push.
    assign push = any && !clear_i && (!full || pop);

    // One-hot grant back to the lane whose event is being pushed.
    always_comb begin
        take = '0;
        for (int i = 0; i < Width; i++) take[i] = push && (sel == IdxW'(i));
    end

    // Event FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ent;
                wr_ptr      <= wr_ptr + PtrW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + DepW'(push) - DepW'(pop);
        end
    end

    // Free-running timestamp, gated by enable, wrapping naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   ts_cnt <= '0;
        else if (en_i) ts_cnt <= ts_cnt + TsWidth'(1);
    end

    // Sticky overflow whenever any lane loses an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      overflow_o <= 1'b0;
        else if (clear_i) overflow_o <= 1'b0;
        else if (|drop)   overflow_o <= 1'b1;
    end

    assign head        = mem[rd_ptr];
    assign evt_valid_o = count != '0;
    assign evt_pin_o   = evt_valid_o ? head.pin  : '0;
    assign evt_rise_o  = evt_valid_o ? head.rise : 1'b0;
    assign evt_ts_o    = evt_valid_o ? head.ts   : '0;
    assign depth_o     = count;
endmodule

// File: tb/tb_pins_event_monitor.sv
// tb_pins_event_monitor: directed tests; dut a is the main instance (4 pins, depth 8),
// dut b has a 2-deep FIFO and 8-bit timestamp, dut c is a single-pin instance.
module tb_pins_event_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pins;
    logic       en, filter_en, clear, ready;

    logic       a_valid, a_rise, a_ovf;
    logic [1:0] a_pin;
    logic [15:0] a_ts;
    logic [3:0] a_stable, a_depth;

    logic       b_valid, b_rise, b_ovf;
    logic [1:0] b_pin, b_depth;
    logic [7:0] b_ts;
    logic [3:0] b_stable;

    logic       c_valid, c_rise, c_ovf, c_pin, c_stable;
    logic [15:0] c_ts;
    logic [2:0] c_depth;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cycles;

    pins_event_monitor #(.Width(4), .FilterCycles(4), .FifoDepth(8), .TsWidth(16), .ResetVal(4'b0000)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .pins_i(pins), .en_i(en), .filter_en_i(filter_en), .clear_i(clear),
        .evt_valid_o(a_valid), .evt_ready_i(ready), .evt_pin_o(a_pin), .evt_rise_o(a_rise), .evt_ts_o(a_ts),
        .stable_o(a_stable), .depth_o(a_depth), .overflow_o(a_ovf));

    pins_event_monitor #(.Width(4), .FilterCycles(4), .FifoDepth(2), .TsWidth(8), .ResetVal(4'b0000)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .pins_i(pins), .en_i(en), .filter_en_i(filter_en), .clear_i(clear),
        .evt_valid_o(b_valid), .evt_ready_i(ready), .evt_pin_o(b_pin), .evt_rise_o(b_rise), .evt_ts_o(b_ts),
        .stable_o(b_stable), .depth_o(b_depth), .overflow_o(b_ovf));

    pins_event_monitor #(.Width(1), .FilterCycles(4), .FifoDepth(4), .TsWidth(16), .ResetVal(1'b0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .pins_i(pins[0]), .en_i(en), .filter_en_i(filter_en), .clear_i(clear),
        .evt_valid_o(c_valid), .evt_ready_i(ready), .evt_pin_o(c_pin), .evt_rise_o(c_rise), .evt_ts_o(c_ts),
        .stable_o(c_stable), .depth_o(c_depth), .overflow_o(c_ovf));

    always #5 clk = ~clk;

    // Reference count of enabled cycles, used only to line up the wrap test.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  en_cycles <= 0;
        else if (en) en_cycles <= en_cycles + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pins = 4'b0000; en = 1'b0; filter_en = 1'b1; clear = 1'b0; ready = 1'b0;
        tick(2);
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h want 0", a_valid); end
        n_tests++; if (a_depth !== 4'd0) begin n_fail++; $display("FAIL rst_depth got %0d want 0", a_depth); end
        n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %0h want 0", a_ovf); end
        n_tests++; if (a_stable !== 4'b0000) begin n_fail++; $display("FAIL rst_stable got %0h want 0", a_stable); end
        n_tests++; if ({a_pin, a_rise, a_ts} !== 19'd0) begin n_fail++; $display("FAIL rst_head got %0h want 0", {a_pin, a_rise, a_ts}); end
        n_tests++; if ({c_valid, c_ovf, c_stable} !== 3'b000) begin n_fail++; $display("FAIL rst_c got %0h want 0", {c_valid, c_ovf, c_stable}); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_unfiltered();
        filter_en = 1'b0; en = 1'b1;
        tick(10);                      // timestamp now 10
        pins = 4'b0001;
        tick(1);
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL lat_k got %0h want 0", a_valid); end
        tick(1);
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL lat_k1 got %0h want 0", a_valid); end
        tick(1);
        n_tests++; if (a_stable !== 4'b0001) begin n_fail++; $display("FAIL lat_stable got %0h want 1", a_stable); end
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL lat_k2 got %0h want 0", a_valid); end
        tick(1);
        n_tests++; if ({a_valid, a_pin, a_rise} !== 4'b1001) begin n_fail++; $display("FAIL lat_k3 got %0h want 9", {a_valid, a_pin, a_rise}); end
        n_tests++; if (a_ts !== 16'd12) begin n_fail++; $display("FAIL rise_ts got %0d want 12", a_ts); end
        n_tests++; if (a_depth !== 4'd1) begin n_fail++; $display("FAIL rise_depth got %0d want 1", a_depth); end
        n_tests++; if ({c_valid, c_pin, c_rise, c_ts, c_depth} !== {3'b101, 16'd12, 3'd1}) begin n_fail++; $display("FAIL c_event got %0h want %0h", {c_valid, c_pin, c_rise, c_ts, c_depth}, {3'b101, 16'd12, 3'd1}); end
        tick(2);                       // consumer stalls: head must hold
        n_tests++; if ({a_valid, a_ts} !== {1'b1, 16'd12}) begin n_fail++; $display("FAIL head_hold got %0h want 1000c", {a_valid, a_ts}); end
        ready = 1'b1; tick(1); ready = 1'b0;   // timestamp now 17
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty got %0h want 0", a_valid); end
        pins = 4'b0000;
        tick(4);
        n_tests++; if ({a_valid, a_pin, a_rise, a_ts} !== {4'b1000, 16'd19}) begin n_fail++; $display("FAIL fall_event got %0h want %0h", {a_valid, a_pin, a_rise, a_ts}, {4'b1000, 16'd19}); end
        ready = 1'b1; tick(1); ready = 1'b0;   // timestamp now 22
    endtask

    task automatic test_filter();
        filter_en = 1'b1;
        pins = 4'b0010; tick(3); pins = 4'b0000; tick(8);   // timestamp now 33
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid got %0h want 0", a_valid); end
        n_tests++; if (a_stable !== 4'b0000) begin n_fail++; $display("FAIL glitch_stable got %0h want 0", a_stable); end
        pins = 4'b0010; tick(5); pins = 4'b0000; tick(12);
        n_tests++; if (a_depth !== 4'd2) begin n_fail++; $display("FAIL pulse_depth got %0d want 2", a_depth); end
        n_tests++; if ({a_pin, a_rise, a_ts} !== {3'b011, 16'd38}) begin n_fail++; $display("FAIL pulse_rise got %0h want %0h", {a_pin, a_rise, a_ts}, {3'b011, 16'd38}); end
        ready = 1'b1; tick(1); ready = 1'b0;
        n_tests++; if ({a_pin, a_rise, a_ts} !== {3'b010, 16'd43}) begin n_fail++; $display("FAIL pulse_fall got %0h want %0h", {a_pin, a_rise, a_ts}, {3'b010, 16'd43}); end
        ready = 1'b1; tick(1); ready = 1'b0;   // timestamp now 52
        n_tests++; if (a_depth !== 4'd0) begin n_fail++; $display("FAIL pulse_drain got %0d want 0", a_depth); end
    endtask

    task automatic test_simultaneous();
        pins = 4'b1001; tick(10);
        n_tests++; if ({a_depth, b_depth} !== {4'd2, 2'd2}) begin n_fail++; $display("FAIL simul_depth got %0h want 22", {a_depth, b_depth}); end
        n_tests++; if ({a_pin, a_rise, a_ts} !== {3'b001, 16'd57}) begin n_fail++; $display("FAIL simul_first got %0h want %0h", {a_pin, a_rise, a_ts}, {3'b001, 16'd57}); end
        ready = 1'b1; tick(1); ready = 1'b0;
        n_tests++; if ({a_pin, a_rise, a_ts} !== {3'b111, 16'd57}) begin n_fail++; $display("FAIL simul_second got %0h want %0h", {a_pin, a_rise, a_ts}, {3'b111, 16'd57}); end
        ready = 1'b1; tick(1); ready = 1'b0;
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drain got %0h want 0", a_valid); end
    endtask

    task automatic test_overflow();
        clear = 1'b1; tick(1); clear = 1'b0;
        pins = 4'b1011; tick(8); pins = 4'b1001; tick(8);
        pins = 4'b1011; tick(8); pins = 4'b1001; tick(8);
        n_tests++; if ({b_depth, b_ovf} !== 3'b101) begin n_fail++; $display("FAIL ovf_state got %0h want 5", {b_depth, b_ovf}); end
        n_tests++; if ({b_pin, b_rise} !== 3'b011) begin n_fail++; $display("FAIL ovf_head got %0h want 3", {b_pin, b_rise}); end
        n_tests++; if ({a_depth, a_ovf} !== 5'b01000) begin n_fail++; $display("FAIL ovf_deep got %0h want 8", {a_depth, a_ovf}); end
        ready = 1'b1; tick(1); ready = 1'b0;   // pending edge refills the freed slot
        n_tests++; if ({b_depth, b_rise} !== 3'b100) begin n_fail++; $display("FAIL ovf_refill got %0h want 4", {b_depth, b_rise}); end
        clear = 1'b1; tick(1); clear = 1'b0;
        n_tests++; if ({b_valid, b_depth, b_ovf} !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear got %0h want 0", {b_valid, b_depth, b_ovf}); end
    endtask

    task automatic test_x_and_disable();
        pins = 4'b10x1; tick(3); pins = 4'b1001; tick(10);
        n_tests++; if ({a_valid, a_ovf} !== 2'b00) begin n_fail++; $display("FAIL x_event got %0h want 0", {a_valid, a_ovf}); end
        n_tests++; if ({a_stable, b_stable} !== 8'h99) begin n_fail++; $display("FAIL x_stable got %0h want 99", {a_stable, b_stable}); end
        en = 1'b0;
        pins = 4'b1011; tick(10);
        n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL dis_event got %0h want 0", a_valid); end
        n_tests++; if (a_stable !== 4'b1011) begin n_fail++; $display("FAIL dis_stable got %0h want b", a_stable); end
        en = 1'b1;
    endtask

    task automatic test_wrap();
        int e;
        filter_en = 1'b0;
        for (int i = 0; i < 300 && (en_cycles % 256) != 253; i++) tick(1);
        n_tests++; if ((en_cycles % 256) != 253) begin n_fail++; $display("FAIL wrap_align got %0d want 253", en_cycles % 256); end
        e = en_cycles;
        pins = 4'b1111;                // pin 2 rises, captured at ts 0xFF
        tick(1);
        pins = 4'b1101;                // pin 1 falls, captured after the wrap
        tick(4);
        n_tests++; if (b_depth !== 2'd2) begin n_fail++; $display("FAIL wrap_depth got %0d want 2", b_depth); end
        n_tests++; if ({b_pin, b_rise, b_ts} !== {3'b101, 8'hFF}) begin n_fail++; $display("FAIL wrap_first got %0h want 5ff", {b_pin, b_rise, b_ts}); end
        n_tests++; if (a_ts !== 16'(e + 2)) begin n_fail++; $display("FAIL wrap_wide got %0h want %0h", a_ts, 16'(e + 2)); end
        ready = 1'b1; tick(1); ready = 1'b0;
        n_tests++; if ({b_pin, b_rise, b_ts} !== {3'b010, 8'h00}) begin n_fail++; $display("FAIL wrap_second got %0h want 200", {b_pin, b_rise, b_ts}); end
        ready = 1'b1; tick(1); ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        pins = 4'b0000; tick(6);       // pins 0, 2, 3 fall
        n_tests++; if ({a_valid, a_depth} !== 5'b10011) begin n_fail++; $display("FAIL mid_queued got %0h want 13", {a_valid, a_depth}); end
        rst_n = 1'b0; #1;
        n_tests++; if ({a_valid, a_depth, a_ovf} !== 6'd0) begin n_fail++; $display("FAIL mid_reset got %0h want 0", {a_valid, a_depth, a_ovf}); end
        n_tests++; if (a_stable !== 4'b0000) begin n_fail++; $display("FAIL mid_stable got %0h want 0", a_stable); end
        tick(2);
        rst_n = 1'b1;
        tick(10);
        n_tests++; if ({a_valid, a_depth, b_valid} !== 6'd0) begin n_fail++; $display("FAIL mid_after got %0h want 0", {a_valid, a_depth, b_valid}); end
    endtask

    initial begin
        test_reset();
        test_unfiltered();
        test_filter();
        test_simultaneous();
        test_overflow();
        test_x_and_disable();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end
endmodule
